// File: rtl/fir_sample_packer_2ch.sv
// Buffers decimated {A,B} FIR output pairs in a small FIFO and serialises each
// pair as four big-endian bytes (sign-extended to 16 bits) on a valid/ready stream.
module fir_sample_packer_2ch #(
  parameter int DATA_WIDTH      = 14,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_2mhz_pos_en,
  input  logic                       din_valid,
  input  logic [DATA_WIDTH-1:0]      din_a,
  input  logic [DATA_WIDTH-1:0]      din_b,
  input  logic                       en,
  output logic [7:0]                 dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       overflow
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] A_HI = 3'd1;
  localparam logic [2:0] A_LO = 3'd2;
  localparam logic [2:0] B_HI = 3'd3;
  localparam logic [2:0] B_LO = 3'd4;

  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);

  logic [2:0]                   state;
  logic                         cap_valid;
  logic [2*DATA_WIDTH-1:0]      cap_pair;
  logic [2*DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2:0]     wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]     rd_ptr;
  logic [23:0]                  shift;
  logic [DATA_WIDTH-1:0]        head_a;
  logic [DATA_WIDTH-1:0]        head_b;
  logic [15:0]                  head_a16;
  logic [15:0]                  head_b16;
  logic                         fire;
  logic                         pop;
  logic                         full;
  logic                         write;

  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == FULL_LEVEL);
  assign fire       = dout_valid & dout_ready;
  assign pop        = (fifo_level != '0) && ((state == IDLE) || ((state == B_LO) && fire));
  assign write      = cap_valid && (!full || pop);

  assign head_a   = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]][2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_b   = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]][DATA_WIDTH-1:0];
  assign head_a16 = 16'($signed(head_a));
  assign head_b16 = 16'($signed(head_b));

  // Capture stage: the strobed pair is registered here and enters the FIFO one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_pair  <= '0;
    end else begin
      cap_valid <= clk_2mhz_pos_en & din_valid & en;
      if (clk_2mhz_pos_en & din_valid & en) begin
        cap_pair <= {din_a, din_b};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= cap_pair;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (cap_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Serialiser: the shift register keeps the three bytes still to be sent after A_HI
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      shift      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift      <= {head_a16[7:0], head_b16};
            dout       <= head_a16[15:8];
            dout_valid <= 1'b1;
            state      <= A_HI;
          end
        end
        A_HI: begin
          if (fire) begin
            dout  <= shift[23:16];
            state <= A_LO;
          end
        end
        A_LO: begin
          if (fire) begin
            dout  <= shift[15:8];
            state <= B_HI;
          end
        end
        B_HI: begin
          if (fire) begin
            dout  <= shift[7:0];
            state <= B_LO;
          end
        end
        B_LO: begin
          if (fire) begin
            if (pop) begin
              shift <= {head_a16[7:0], head_b16};
              dout  <= head_a16[15:8];
              state <= A_HI;
            end else begin
              dout_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_packer_2ch.sv
// Self-checking bench for fir_sample_packer_2ch: directed scenarios plus random
// traffic, compared each cycle against a queue-based model of the packer.
module tb_fir_sample_packer_2ch;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic        din_valid;
  logic [13:0] din_a;
  logic [13:0] din_b;
  logic        en;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  fifo_level;
  logic        overflow;

  int error_count;
  int check_count;

  // Model: pairs waiting in the FIFO, bytes left of the pair being sent, capture stage
  logic [31:0] fifo_q[$];
  logic [7:0]  cur_q[$];
  bit          staged_v;
  logic [31:0] staged_p;
  bit          m_ovf;

  fir_sample_packer_2ch #(
    .DATA_WIDTH(14),
    .FIFO_DEPTH(16),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_2mhz_pos_en(strobe),
    .din_valid(din_valid),
    .din_a(din_a),
    .din_b(din_b),
    .en(en),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sext14(logic [13:0] v);
    int s;
    s = int'(v);
    if (s >= 8192) s = s - 16384;
    return 16'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelEdge();
    logic [31:0] p;
    bit full_pre;
    bit pop;
    if (!rst_n) begin
      fifo_q.delete();
      cur_q.delete();
      staged_v = 0;
      m_ovf    = 0;
      return;
    end
    full_pre = (fifo_q.size() == 16);
    if (cur_q.size() > 0 && dout_ready) void'(cur_q.pop_front());
    pop = (cur_q.size() == 0) && (fifo_q.size() > 0);
    if (pop) begin
      p = fifo_q.pop_front();
      cur_q.push_back(p[31:24]);
      cur_q.push_back(p[23:16]);
      cur_q.push_back(p[15:8]);
      cur_q.push_back(p[7:0]);
    end
    if (staged_v) begin
      if (full_pre && !pop) m_ovf = 1;
      else fifo_q.push_back(staged_p);
    end
    staged_v = strobe && din_valid && en;
    staged_p = {sext14(din_a), sext14(din_b)};
  endtask

  // One clock: inputs already driven, model steps at the edge, outputs compared at negedge
  task automatic applyStimulus(input bit s, input bit dv, input bit e,
                               input logic [13:0] a, input logic [13:0] b, input bit rdy);
    strobe     = s;
    din_valid  = dv;
    en         = e;
    din_a      = a;
    din_b      = b;
    dout_ready = rdy;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput("dout_valid", 32'(dout_valid), 32'(cur_q.size() > 0));
    checkOutput("fifo_level", 32'(fifo_level), 32'(fifo_q.size()));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    if (cur_q.size() > 0) checkOutput("dout", 32'(dout), 32'(cur_q[0]));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 1, 14'h0, 14'h0, rdy);
  endtask

  initial begin
    logic [7:0] s1_bytes [4];
    error_count = 0;
    check_count = 0;
    staged_v = 0;
    m_ovf    = 0;
    s1_bytes[0] = 8'hE0; s1_bytes[1] = 8'h01; s1_bytes[2] = 8'h01; s1_bytes[3] = 8'h23;

    rst_n = 1'b0;
    idle(3, 1);
    checkOutput("reset_dout", 32'(dout), 32'h0);
    checkOutput("reset_level", 32'(fifo_level), 32'h0);
    rst_n = 1'b1;
    idle(2, 1);

    $display("[TB] single pair, ready high");
    applyStimulus(1, 1, 1, 14'h2001, 14'h0123, 1);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(0, 1, 1, 14'h0, 14'h0, 1);
      if (k == 1) checkOutput("s1_level_after_push", 32'(fifo_level), 32'd1);
      if (k >= 2 && k <= 5) begin
        checkOutput("s1_valid", 32'(dout_valid), 32'd1);
        checkOutput("s1_byte", 32'(dout), 32'(s1_bytes[k-2]));
      end
      if (k == 6) checkOutput("s1_valid_low", 32'(dout_valid), 32'd0);
    end

    $display("[TB] ready toggling");
    applyStimulus(1, 1, 1, 14'h2001, 14'h0123, 1);
    for (int k = 0; k < 14; k++) applyStimulus(0, 1, 1, 14'h0, 14'h0, (k % 2) == 0);
    idle(4, 1);

    $display("[TB] fill and overflow with ready low");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1, 1, 1, 14'(i), 14'(-i), 0);
      idle(19, 0);
    end
    checkOutput("s3_level_full", 32'(fifo_level), 32'd16);
    checkOutput("s3_overflow", 32'(overflow), 32'd1);
    idle(80, 1);
    checkOutput("s3_drained", 32'(fifo_level), 32'd0);

    $display("[TB] back-to-back pairs");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 14'($urandom), 14'($urandom), 0);
    idle(3, 0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 1, 14'h0, 14'h0, 1);
      if (k < 11) checkOutput("s4_continuous", 32'(dout_valid), 32'd1);
    end
    idle(2, 1);
    checkOutput("s4_valid_low", 32'(dout_valid), 32'd0);

    $display("[TB] reset mid-pair");
    applyStimulus(1, 1, 1, 14'h1234, 14'h3FFF, 1);
    idle(4, 1);
    rst_n = 1'b0;
    idle(1, 1);
    rst_n = 1'b1;
    checkOutput("s5_valid", 32'(dout_valid), 32'd0);
    checkOutput("s5_overflow", 32'(overflow), 32'd0);
    checkOutput("s5_level", 32'(fifo_level), 32'd0);
    idle(3, 1);
    applyStimulus(1, 1, 1, 14'h0005, 14'h0006, 1);
    idle(2, 1);
    checkOutput("s5_fresh_a_hi", 32'(dout), 32'h00);
    idle(1, 1);
    checkOutput("s5_fresh_a_lo", 32'(dout), 32'h05);
    idle(5, 1);

    $display("[TB] captures disabled");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 14'($urandom), 14'($urandom), 1);
      idle(3, 1);
      applyStimulus(1, 0, 1, 14'($urandom), 14'($urandom), 1);
      idle(3, 1);
    end
    checkOutput("s6_level", 32'(fifo_level), 32'd0);
    checkOutput("s6_no_bytes", 32'(dout_valid), 32'd0);

    $display("[TB] random traffic");
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                    14'($urandom), 14'($urandom), $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    idle(100, 1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
